// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default frame geometry.
// The optional parity bit is selected at build time with UART_RX_PARITY_EN.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int DEF_NB_BITS = 8;
    localparam int DEF_N_TICKS = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the UART receiver: serial line, oversample tick, word and strobes.
// state mirrors the receiver FSM for observation; UART_RX_PARITY_EN does not change this bundle.
interface uart_rx_if
    import uart_rx_pkg::*;
#(
    parameter int NB_BITS = DEF_NB_BITS
);
    // Handshake: the receiver has no back-pressure. o_rx_done, o_frame_err and o_parity_err
    // are single-cycle strobes; o_data is valid from the o_rx_done cycle until the next one.
    logic               i_rx;
    logic               i_tick;
    logic [NB_BITS-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;
    logic               o_parity_err;
    rx_state_e          state;

    modport master (
        output i_rx,
        output i_tick,
        input  o_data,
        input  o_rx_done,
        input  o_frame_err,
        input  o_parity_err,
        input  state
    );

    modport slave (
        input  i_rx,
        input  i_tick,
        output o_data,
        output o_rx_done,
        output o_frame_err,
        output o_parity_err,
        output state
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
// All flops reset to the idle-high line level, so reset never fakes a start edge.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rx_s = sync;
    assign fall = prev & ~sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, NB_BITS data (LSB first), optional even parity, 1 stop bit.
// Define UART_RX_PARITY_EN to expect a parity bit; otherwise o_parity_err is tied low.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int NB_BITS = DEF_NB_BITS,
    parameter int N_TICKS = DEF_N_TICKS
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    uart_rx_if.slave  bus
);

    localparam int TW = $clog2(N_TICKS);
    localparam int BW = $clog2(NB_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(N_TICKS / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(N_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NB_BITS - 1);

    logic               rx_s;
    logic               fall;
    rx_state_e          state;
    logic [TW-1:0]      tick_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [NB_BITS-1:0] shreg;
    logic [NB_BITS-1:0] data_q;
    logic               done_q;
    logic               ferr_q;
`ifdef UART_RX_PARITY_EN
    logic               par_bit;
    logic               perr_q;
`endif

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .rx      (bus.i_rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );

    // Every sample after the start-bit centre lands one full bit period later,
    // so DATA, PARITY and STOP all fire on tick_cnt == N_TICKS-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Only a 1->0 edge arms; a line stuck low stays ignored.
                    if (fall) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end

                START: begin
                    if (bus.i_tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (bus.i_tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= NB_BITS'({rx_s, shreg} >> 1);
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bus.i_tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            par_bit  <= rx_s;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (bus.i_tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (rx_s) begin
                                data_q <= shreg;
                                done_q <= 1'b1;
                            end else begin
                                ferr_q <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            perr_q <= (^shreg) ^ par_bit;
`endif
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_rx_done   = done_q;
    assign bus.o_frame_err = ferr_q;
    assign bus.state       = state;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = perr_q;
`else
    assign bus.o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (N_TICKS=16, tick every 4 clocks, 64 clocks per bit).
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int NB  = 8;
    localparam int BIT = 64;
    localparam int W   = NB + 3;

    logic clk;
    logic rst_n;

    uart_rx_if #(.NB_BITS(NB)) bus ();

    uart_rx #(.NB_BITS(NB), .N_TICKS(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0]  exp_q[$];
    logic [NB-1:0] last_good = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        bus.i_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.i_tick = 1'b1;
            @(negedge clk);
            bus.i_tick = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.i_rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    // Expected event word: {parity_err, frame_err, done, data}
    task automatic send_frame(input logic [NB-1:0] data, input logic stop_bit, input logic par_bit);
        logic perr;
`ifdef UART_RX_PARITY_EN
        perr = par_bit ^ (^data);
`else
        perr = 1'b0;
`endif
        if (stop_bit) begin
            exp_q.push_back({perr, 1'b0, 1'b1, data});
            last_good = data;
        end else begin
            exp_q.push_back({perr, 1'b1, 1'b0, last_good});
        end
        send_bit(1'b0);
        for (int i = 0; i < NB; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`endif
        send_bit(stop_bit);
    endtask

    task automatic send_good(input logic [NB-1:0] data);
        send_frame(data, 1'b1, ^data);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_data"}, 32'(bus.o_data), 32'h0);
        chk({tag, "_done"}, 32'(bus.o_rx_done), 32'h0);
        chk({tag, "_ferr"}, 32'(bus.o_frame_err), 32'h0);
        chk({tag, "_perr"}, 32'(bus.o_parity_err), 32'h0);
        chk({tag, "_state"}, 32'(bus.state), 32'(IDLE));
    endtask

    always @(negedge clk) begin
        logic [W-1:0] obs;
        if (rst_n && (bus.o_rx_done || bus.o_frame_err || bus.o_parity_err)) begin
            obs = {bus.o_parity_err, bus.o_frame_err, bus.o_rx_done, bus.o_data};
            if (exp_q.size() == 0) chk("spurious_strobe", 32'(obs), 32'h0);
            else chk("rx_event", 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        bus.i_rx = 1'b1;
        rst_n    = 1'b0;
        repeat (5) @(negedge clk);
        chk_cleared("reset");
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);

        // 1: basic frame
        send_good(8'hA5);
        send_bit(1'b1);

        // 2: short low glitch is rejected, then a good frame
        bus.i_rx = 1'b0;
        repeat (16) @(negedge clk);
        bus.i_rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("glitch_idle", 32'(bus.state), 32'(IDLE));
        send_good(8'h3C);
        send_bit(1'b1);

        // 3: bad stop bit, then line held low must not re-arm
        send_frame(8'hC3, 1'b0, ^8'hC3);
        repeat (3 * BIT) @(negedge clk);
        chk("stuck_low_idle", 32'(bus.state), 32'(IDLE));
        chk("stuck_low_data", 32'(bus.o_data), 32'(last_good));
        send_bit(1'b1);

        // 4: asynchronous reset during data bit 3
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(i[0]);
        bus.i_rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        chk("pre_reset_state", 32'(bus.state), 32'(DATA));
        #2 rst_n = 1'b0;
        #1 chk_cleared("mid_reset");
        last_good = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);
        send_good(8'h5A);
        send_bit(1'b1);

        // 5: back-to-back frames, no idle gap
        send_good(8'h00);
        send_good(8'hFF);
        send_bit(1'b1);

        // random payloads
        for (int i = 0; i < 4; i++) send_good(NB'($urandom_range(0, 255)));
        send_bit(1'b1);

`ifdef UART_RX_PARITY_EN
        // 6: parity mismatch and match
        send_frame(8'h07, 1'b1, 1'b0);
        send_bit(1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        send_bit(1'b1);
`endif

        for (int i = 0; i < 4 * BIT && exp_q.size() != 0; i++) @(negedge clk);
        chk("pending_events", 32'(exp_q.size()), 32'h0);
        chk("final_state", 32'(bus.state), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
